// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 4-master round-robin bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned SEL_W       = 2;

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  localparam logic [SEL_W-1:0] M_IFETCH = 2'd0;
  localparam logic [SEL_W-1:0] M_DATA   = 2'd1;
  localparam logic [SEL_W-1:0] M_DEBUG  = 2'd2;
  localparam logic [SEL_W-1:0] M_DMA    = 2'd3;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_4_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface bus_arbiter_4_if;
  import bus_arb_pkg::*;

  logic [NUM_MASTERS-1:0] req;
  logic                   done;
  logic [NUM_MASTERS-1:0] gnt;
  logic [SEL_W-1:0]       sel;
  logic                   busy;
  logic                   timeout_err;
  logic [SEL_W-1:0]       err_id;

  // Arbiter side
  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout_err, err_id
  );

  // Requester / environment side
  modport master (
    output req, done,
    input  gnt, sel, busy, timeout_err, err_id
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first request found searching ptr, ptr+1, ... mod 4.
module rr_pick4 import bus_arb_pkg::*; (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [SEL_W-1:0]       ptr,
  output logic                   valid,
  output logic [SEL_W-1:0]       idx
);

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      logic [SEL_W-1:0] cand;
      cand = ptr + SEL_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter for the shared 32-bit bus: one transaction per grant,
// same-edge re-arbitration on release, and a watchdog that reclaims a stalled owner.
module bus_arbiter_4 import bus_arb_pkg::*; #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_arbiter_4_if.slave  bus
);

  localparam bit         WdEn    = (TIMEOUT != 0);
  localparam logic [7:0] CntLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   terr_q, terr_d;
  logic [SEL_W-1:0]       err_id_q, err_id_d;

  logic                   pick_valid;
  logic [SEL_W-1:0]       pick_idx;
  logic                   arbitrate;
  logic                   owner_req;
  logic                   wd_hit;

  // ptr_q already sits one past the current owner, so a releasing owner is searched last.
  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = bus.req[sel_q];
  assign wd_hit    = WdEn && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    terr_d    = 1'b0;
    err_id_d  = err_id_q;
    arbitrate = 1'b0;

    unique case (state_q)
      IDLE: arbitrate = 1'b1;
      OWN: begin
        if (bus.done || !owner_req || wd_hit) begin
          arbitrate = 1'b1;
          // Completion and abort take precedence over the watchdog.
          if (!bus.done && owner_req) begin
            terr_d   = 1'b1;
            err_id_d = sel_q;
          end
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    if (arbitrate) begin
      if (pick_valid) begin
        state_d = OWN;
        gnt_d   = onehot(pick_idx);
        sel_d   = pick_idx;
        ptr_d   = pick_idx + SEL_W'(1);
        cnt_d   = 8'd0;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      sel_q    <= M_IFETCH;
      terr_q   <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      terr_q   <= terr_d;
      err_id_q <= err_id_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = |gnt_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_id      = err_id_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 (TIMEOUT=4): grant latency, rotation, fairness,
// watchdog, abort and asynchronous reset.
module tb_bus_arbiter_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  bus_arbiter_4_if bus ();

  bus_arbiter_4 #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    #12;
    tests++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout_err, bus.err_id} !== 10'b0) begin
      failed++;
      $display("FAIL reset_values: gnt=%b sel=%0d busy=%b terr=%b err_id=%0d, expected all 0",
               bus.gnt, bus.sel, bus.busy, bus.timeout_err, bus.err_id);
    end
    bus.req = 4'b1111;
    tick();
    tests++;
    if (bus.gnt !== 4'b0000) begin
      failed++;
      $display("FAIL reset_holds: gnt=%b, expected 0000", bus.gnt);
    end
    bus.req = 4'b0000;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0010;
    tick();
    tests++;
    if ({bus.gnt, bus.sel, bus.busy} !== {4'b0010, 2'd1, 1'b1}) begin
      failed++;
      $display("FAIL single_grant: gnt=%b sel=%0d busy=%b, expected 0010/1/1",
               bus.gnt, bus.sel, bus.busy);
    end
    tick();
    tick();
    bus.done = 1'b1;
    bus.req  = 4'b0000;
    tick();
    bus.done = 1'b0;
    tests++;
    if ({bus.gnt, bus.sel, bus.busy, bus.timeout_err} !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL single_release: gnt=%b sel=%0d busy=%b terr=%b, expected 0000/1/0/0",
               bus.gnt, bus.sel, bus.busy, bus.timeout_err);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++;
    if ({bus.gnt, bus.sel, bus.busy} !== {4'b0000, 2'd1, 1'b0}) begin
      failed++;
      $display("FAIL done_in_idle: gnt=%b sel=%0d busy=%b, expected 0000/1/0",
               bus.gnt, bus.sel, bus.busy);
    end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    tick();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      failed++;
      $display("FAIL all_first: gnt=%b, expected 0001", bus.gnt);
    end
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0001 << k;
      tick();
      tests++;
      if (bus.gnt !== exp_gnt) begin
        failed++;
        $display("FAIL all_hold[%0d]: gnt=%b, expected %b", k, bus.gnt, exp_gnt);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      exp_gnt = 4'b0001 << ((k + 1) % 4);
      tests++;
      if ({bus.gnt, bus.sel, bus.busy} !== {exp_gnt, 2'((k + 1) % 4), 1'b1}) begin
        failed++;
        $display("FAIL all_handover[%0d]: gnt=%b sel=%0d busy=%b, expected %b/%0d/1",
                 k, bus.gnt, bus.sel, bus.busy, exp_gnt, (k + 1) % 4);
      end
    end
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++;
    if ({bus.gnt, bus.sel, bus.busy} !== {4'b0000, 2'd0, 1'b0}) begin
      failed++;
      $display("FAIL all_idle: gnt=%b sel=%0d busy=%b, expected 0000/0/0",
               bus.gnt, bus.sel, bus.busy);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b0101;
    tick();
    tests++;
    if (bus.gnt !== 4'b0001) begin
      failed++;
      $display("FAIL fair_first: gnt=%b, expected 0001", bus.gnt);
    end
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 4'b0100 : 4'b0001;
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tests++;
      if (bus.gnt !== exp_gnt) begin
        failed++;
        $display("FAIL fair_alt[%0d]: gnt=%b, expected %b", k, bus.gnt, exp_gnt);
      end
      tick();
    end
    bus.req  = 4'b0000;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b1010;
    tests++;
    if ({bus.gnt, bus.sel, bus.timeout_err} !== {4'b1000, 2'd3, 1'b0}) begin
      failed++;
      $display("FAIL wd_grant: gnt=%b sel=%0d terr=%b, expected 1000/3/0",
               bus.gnt, bus.sel, bus.timeout_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({bus.gnt, bus.timeout_err} !== {4'b1000, 1'b0}) begin
        failed++;
        $display("FAIL wd_hold[%0d]: gnt=%b terr=%b, expected 1000/0",
                 i, bus.gnt, bus.timeout_err);
      end
    end
    tick();
    tests++;
    if ({bus.gnt, bus.sel, bus.timeout_err, bus.err_id} !== {4'b0010, 2'd1, 1'b1, 2'd3}) begin
      failed++;
      $display("FAIL wd_fire: gnt=%b sel=%0d terr=%b err_id=%0d, expected 0010/1/1/3",
               bus.gnt, bus.sel, bus.timeout_err, bus.err_id);
    end
    tick();
    tests++;
    if ({bus.gnt, bus.timeout_err, bus.err_id} !== {4'b0010, 1'b0, 2'd3}) begin
      failed++;
      $display("FAIL wd_pulse_end: gnt=%b terr=%b err_id=%0d, expected 0010/0/3",
               bus.gnt, bus.timeout_err, bus.err_id);
    end
    tick();
    tick();
    // Master 1 is now at its last watchdog cycle; DONE on that edge wins.
    bus.done = 1'b1;
    bus.req  = 4'b0000;
    tick();
    bus.done = 1'b0;
    tests++;
    if ({bus.gnt, bus.timeout_err, bus.err_id} !== {4'b0000, 1'b0, 2'd3}) begin
      failed++;
      $display("FAIL wd_done_wins: gnt=%b terr=%b err_id=%0d, expected 0000/0/3",
               bus.gnt, bus.timeout_err, bus.err_id);
    end
    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    bus.req = 4'b0000;
    tick();
    tests++;
    if ({bus.gnt, bus.timeout_err, bus.err_id} !== {4'b0000, 1'b0, 2'd3}) begin
      failed++;
      $display("FAIL wd_abort_wins: gnt=%b terr=%b err_id=%0d, expected 0000/0/3",
               bus.gnt, bus.timeout_err, bus.err_id);
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    bus.req = 4'b0100;
    tick();
    tick();
    tests++;
    if (bus.gnt !== 4'b0100) begin
      failed++;
      $display("FAIL abort_owner: gnt=%b, expected 0100", bus.gnt);
    end
    bus.req = 4'b0000;
    tick();
    tests++;
    if ({bus.gnt, bus.busy, bus.timeout_err} !== {4'b0000, 1'b0, 1'b0}) begin
      failed++;
      $display("FAIL abort_release: gnt=%b busy=%b terr=%b, expected 0000/0/0",
               bus.gnt, bus.busy, bus.timeout_err);
    end
    bus.req = 4'b0010;
    tick();
    tests++;
    if ({bus.gnt, bus.sel} !== {4'b0010, 2'd1}) begin
      failed++;
      $display("FAIL abort_regrant: gnt=%b sel=%0d, expected 0010/1", bus.gnt, bus.sel);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.gnt, bus.sel, bus.busy} !== {4'b0000, 2'd0, 1'b0}) begin
      failed++;
      $display("FAIL async_reset: gnt=%b sel=%0d busy=%b, expected 0000/0/0",
               bus.gnt, bus.sel, bus.busy);
    end
    bus.req = 4'b1001;
    #2;
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.gnt, bus.sel, bus.busy} !== {4'b0001, 2'd0, 1'b1}) begin
      failed++;
      $display("FAIL post_reset_prio: gnt=%b sel=%0d busy=%b, expected 0001/0/1",
               bus.gnt, bus.sel, bus.busy);
    end
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_watchdog();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
